// File: rtl/shiftreg_univ_if.sv
// Bundle of the shift register's control, data and status signals.
//   master : drives mode/rot/din_fwd/din_bwd/pin, observes the outputs
//   slave  : the shift register itself
// Ports carried:
//   mode, rot, din_fwd, din_bwd, pin    (master -> slave)
//   pout, dout_fwd, dout_bwd, vld_fwd,
//   vld_bwd, fill, full                 (slave -> master)
interface shiftreg_univ_if #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4,
   parameter int FW    = $clog2(DEPTH + 1)
);
   logic [1:0]             mode;
   logic                   rot;
   logic [WIDTH-1:0]       din_fwd;
   logic [WIDTH-1:0]       din_bwd;
   logic [WIDTH*DEPTH-1:0] pin;
   logic [WIDTH*DEPTH-1:0] pout;
   logic [WIDTH-1:0]       dout_fwd;
   logic [WIDTH-1:0]       dout_bwd;
   logic                   vld_fwd;
   logic                   vld_bwd;
   logic [FW-1:0]          fill;
   logic                   full;

   modport master (
      output mode, rot, din_fwd, din_bwd, pin,
      input  pout, dout_fwd, dout_bwd, vld_fwd, vld_bwd, fill, full
   );

   modport slave (
      input  mode, rot, din_fwd, din_bwd, pin,
      output pout, dout_fwd, dout_bwd, vld_fwd, vld_bwd, fill, full
   );
endinterface

// File: rtl/shiftreg_univ.sv
// Universal shift register: DEPTH stages of WIDTH bits, each with a valid bit.
// Modes: 00 hold, 01 forward shift (stage 0 -> DEPTH-1), 10 backward shift,
// 11 parallel load. rot turns a shift into a rotate.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, priority over mode
//   bus  : shiftreg_univ_if.slave (mode, rot, din_fwd, din_bwd, pin in;
//          pout, dout_fwd, dout_bwd, vld_fwd, vld_bwd, fill, full out)
// Every output is a register or a slice of one; nothing on the input side
// reaches an output combinationally.
module shiftreg_univ #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   shiftreg_univ_if.slave bus
);
   localparam int FW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][WIDTH-1:0] q, q_nxt;
   logic [DEPTH-1:0]            v, v_nxt;
   logic [FW-1:0]               fill_r, fill_nxt;
   logic                        full_r, full_nxt;

   always_comb begin
      q_nxt = q;
      v_nxt = v;
      case (bus.mode)
         2'b01: begin
            for (int i = 1; i < DEPTH; i++) begin
               q_nxt[i] = q[i-1];
               v_nxt[i] = v[i-1];
            end
            if (bus.rot) begin
               q_nxt[0] = q[DEPTH-1];
               v_nxt[0] = v[DEPTH-1];
            end else begin
               q_nxt[0] = bus.din_fwd;
               v_nxt[0] = 1'b1;
            end
         end
         2'b10: begin
            for (int i = 0; i < DEPTH-1; i++) begin
               q_nxt[i] = q[i+1];
               v_nxt[i] = v[i+1];
            end
            if (bus.rot) begin
               q_nxt[DEPTH-1] = q[0];
               v_nxt[DEPTH-1] = v[0];
            end else begin
               q_nxt[DEPTH-1] = bus.din_bwd;
               v_nxt[DEPTH-1] = 1'b1;
            end
         end
         2'b11: begin
            q_nxt = bus.pin;
            v_nxt = '1;
         end
         default: begin
         end
      endcase

      // fill/full are computed from the next valid vector so they are
      // registered alongside v and never lag it by a cycle.
      fill_nxt = '0;
      for (int i = 0; i < DEPTH; i++)
         fill_nxt = fill_nxt + FW'(v_nxt[i]);
      full_nxt = (fill_nxt == FW'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q      <= '0;
         v      <= '0;
         fill_r <= '0;
         full_r <= 1'b0;
      end else begin
         q      <= q_nxt;
         v      <= v_nxt;
         fill_r <= fill_nxt;
         full_r <= full_nxt;
      end
   end

   assign bus.pout     = q;
   assign bus.dout_fwd = q[DEPTH-1];
   assign bus.dout_bwd = q[0];
   assign bus.vld_fwd  = v[DEPTH-1];
   assign bus.vld_bwd  = v[0];
   assign bus.fill     = fill_r;
   assign bus.full     = full_r;
endmodule

// File: tb/tb_shiftreg_univ.sv
module tb_shiftreg_univ;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, rst8;

   shiftreg_univ_if #(.WIDTH(1), .DEPTH(4)) b1 ();
   shiftreg_univ_if #(.WIDTH(8), .DEPTH(4)) b8 ();

   shiftreg_univ #(.WIDTH(1), .DEPTH(4)) dut1 (.clk(clk), .rst(rst1), .bus(b1));
   shiftreg_univ #(.WIDTH(8), .DEPTH(4)) dut8 (.clk(clk), .rst(rst8), .bus(b8));

   int checks = 0;
   int errors = 0;

   // expected word for the 8-bit instance:
   // {pout[31:0], fill[2:0], vld_fwd, vld_bwd, full, dout_fwd[7:0], dout_bwd[7:0]}
   logic [53:0] q8[$];
   // expected word for the 1-bit instance: {dout_fwd, vld_fwd, fill[2:0], full}
   logic [5:0]  q1[$];

   function automatic logic [53:0] exp8(input logic [31:0] p, input logic [2:0] f,
                                        input logic [3:0] v);
      return {p, f, v[3], v[0], (f == 3'd4), p[31:24], p[7:0]};
   endfunction

   task automatic drive8(input logic r, input logic [1:0] m, input logic ro,
                         input logic [7:0] df, input logic [7:0] db,
                         input logic [31:0] p);
      rst8       = r;
      b8.mode    = m;
      b8.rot     = ro;
      b8.din_fwd = df;
      b8.din_bwd = db;
      b8.pin     = p;
   endtask

   task automatic test_reset;
      logic [53:0] e, got;
      logic [5:0]  e1, got1;
      // reset must win over a parallel load on the same edge
      drive8(1'b1, 2'b11, 1'b0, 8'h00, 8'h00, 32'hDEADBEEF);
      rst1 = 1'b1; b1.mode = 2'b11; b1.pin = 4'hF;
      q8.push_back(exp8(32'h0, 3'd0, 4'b0000));
      q1.push_back(6'b0);
      @(posedge clk); #1;
      e = q8.pop_front();
      got = {b8.pout, b8.fill, b8.vld_fwd, b8.vld_bwd, b8.full, b8.dout_fwd, b8.dout_bwd};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL reset8 got %h expected %h", got, e);
      end
      e1 = q1.pop_front();
      got1 = {b1.dout_fwd, b1.vld_fwd, b1.fill, b1.full};
      checks++;
      if (got1 !== e1) begin
         errors++;
         $display("FAIL reset1 got %b expected %b", got1, e1);
      end
   endtask

   task automatic test_serial_fwd;
      logic [6:0] din  = 7'b0001101; // bit k is din for edge k+1: 1,0,1,1,0,0,0
      logic [6:0] dout = 7'b1101000; // bit k: 0,0,0,1,0,1,1
      logic [6:0] vf   = 7'b1111000;
      logic [5:0] e, got;
      logic [2:0] f;
      rst1 = 1'b0; b1.mode = 2'b01; b1.rot = 1'b0;
      for (int k = 0; k < 7; k++) begin
         b1.din_fwd = din[k];
         f = (k < 4) ? 3'(k + 1) : 3'd4;
         q1.push_back({dout[k], vf[k], f, (f == 3'd4)});
         @(posedge clk); #1;
         e = q1.pop_front();
         got = {b1.dout_fwd, b1.vld_fwd, b1.fill, b1.full};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL serial_fwd edge %0d got %b expected %b", k + 1, got, e);
         end
      end
   endtask

   task automatic test_load_rotate;
      logic [31:0] exp_p[5] = '{32'h44332211, 32'h33221144, 32'h22114433,
                                 32'h11443322, 32'h44332211};
      logic [53:0] e, got;
      for (int k = 0; k < 5; k++) begin
         if (k == 0) drive8(1'b0, 2'b11, 1'b1, 8'h00, 8'h00, 32'h44332211);
         else        drive8(1'b0, 2'b01, 1'b1, 8'hEE, 8'hEE, 32'h0);
         q8.push_back(exp8(exp_p[k], 3'd4, 4'b1111));
         @(posedge clk); #1;
         e = q8.pop_front();
         got = {b8.pout, b8.fill, b8.vld_fwd, b8.vld_bwd, b8.full, b8.dout_fwd, b8.dout_bwd};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL load_rotate step %0d got %h expected %h", k, got, e);
         end
      end
   endtask

   task automatic test_backward_reversal;
      logic [53:0] e, got;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: begin
               drive8(1'b0, 2'b11, 1'b0, 8'h00, 8'h00, 32'h44332211);
               q8.push_back(exp8(32'h44332211, 3'd4, 4'b1111));
            end
            1: begin
               drive8(1'b0, 2'b10, 1'b0, 8'h00, 8'hAA, 32'h0);
               q8.push_back(exp8(32'hAA443322, 3'd4, 4'b1111));
            end
            2: begin
               drive8(1'b0, 2'b01, 1'b0, 8'h55, 8'h00, 32'h0);
               q8.push_back(exp8(32'h44332255, 3'd4, 4'b1111));
            end
            default: begin
               drive8(1'b0, 2'b10, 1'b0, 8'h00, 8'hBB, 32'h0);
               q8.push_back(exp8(32'hBB443322, 3'd4, 4'b1111));
            end
         endcase
         @(posedge clk); #1;
         e = q8.pop_front();
         got = {b8.pout, b8.fill, b8.vld_fwd, b8.vld_bwd, b8.full, b8.dout_fwd, b8.dout_bwd};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL backward step %0d got %h expected %h", k, got, e);
         end
      end
   endtask

   task automatic test_hold_partial_brot;
      logic [53:0] e, got;
      for (int k = 0; k < 9; k++) begin
         if (k == 0) begin
            drive8(1'b1, 2'b01, 1'b0, 8'h77, 8'h77, 32'h0);
            q8.push_back(exp8(32'h0, 3'd0, 4'b0000));
         end else if (k == 1) begin
            drive8(1'b0, 2'b01, 1'b0, 8'h11, 8'h00, 32'h0);
            q8.push_back(exp8(32'h00000011, 3'd1, 4'b0001));
         end else if (k == 2) begin
            drive8(1'b0, 2'b01, 1'b0, 8'h22, 8'h00, 32'h0);
            q8.push_back(exp8(32'h00001122, 3'd2, 4'b0011));
         end else if (k < 8) begin
            // hold with everything else wiggling; nothing may move
            drive8(1'b0, 2'b00, k[0], 8'($urandom), 8'($urandom), $urandom);
            q8.push_back(exp8(32'h00001122, 3'd2, 4'b0011));
         end else begin
            drive8(1'b0, 2'b10, 1'b1, 8'h00, 8'h99, 32'h0);
            q8.push_back(exp8(32'h22000011, 3'd2, 4'b1001));
         end
         @(posedge clk); #1;
         e = q8.pop_front();
         got = {b8.pout, b8.fill, b8.vld_fwd, b8.vld_bwd, b8.full, b8.dout_fwd, b8.dout_bwd};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL hold_brot step %0d got %h expected %h", k, got, e);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [53:0] e, got;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) begin
            drive8(1'b0, 2'b11, 1'b0, 8'h00, 8'h00, 32'h44332211);
            q8.push_back(exp8(32'h44332211, 3'd4, 4'b1111));
         end else if (k == 1) begin
            drive8(1'b1, 2'b01, 1'b0, 8'hFF, 8'h00, 32'h0);
            q8.push_back(exp8(32'h0, 3'd0, 4'b0000));
         end else begin
            drive8(1'b0, 2'b01, 1'b0, 8'h5A, 8'h00, 32'h0);
            q8.push_back(exp8(32'h0000005A, 3'd1, 4'b0001));
         end
         @(posedge clk); #1;
         e = q8.pop_front();
         got = {b8.pout, b8.fill, b8.vld_fwd, b8.vld_bwd, b8.full, b8.dout_fwd, b8.dout_bwd};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset_mid step %0d got %h expected %h", k, got, e);
         end
      end
   endtask

   task automatic test_fill_saturate;
      logic [53:0] e, got;
      logic [31:0] p = 32'h0;
      logic [3:0]  v = 4'b0000;
      logic [2:0]  f = 3'd0;
      logic [7:0]  d;
      drive8(1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 32'h0);
      @(posedge clk); #1;
      for (int k = 0; k < 7; k++) begin
         d = 8'(8'hA0 + k);
         drive8(1'b0, 2'b01, 1'b0, d, 8'h00, 32'h0);
         p = {p[23:0], d};
         v = {v[2:0], 1'b1};
         f = (f == 3'd4) ? 3'd4 : f + 3'd1;
         q8.push_back(exp8(p, f, v));
         @(posedge clk); #1;
         e = q8.pop_front();
         got = {b8.pout, b8.fill, b8.vld_fwd, b8.vld_bwd, b8.full, b8.dout_fwd, b8.dout_bwd};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL fill_saturate step %0d got %h expected %h", k, got, e);
         end
      end
   endtask

   initial begin
      rst1 = 1'b1; b1.mode = 2'b00; b1.rot = 1'b0;
      b1.din_fwd = '0; b1.din_bwd = '0; b1.pin = '0;
      drive8(1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 32'h0);
      @(posedge clk); #1;
      test_reset();
      test_serial_fwd();
      test_load_rotate();
      test_backward_reversal();
      test_hold_partial_brot();
      test_reset_mid();
      test_fill_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
